// File: rtl/disp_consumer_pkg.sv
// Shared types and constants for the clk_2 read-side display consumer:
// FSM encoding, source tags, segment codes and the double-dabble step.
package disp_consumer_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StConv   = 2'd1,
        StCommit = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TagNone  = 2'd0,
        TagFib   = 2'd1,
        TagTimer = 2'd2,
        TagRsvd  = 2'd3
    } tag_e;

    localparam int unsigned BinW = 16;
    localparam int unsigned BcdW = 20;

    // Segment bytes are {a,b,c,d,e,f,g,dp}, active-low, dp always off.
    localparam logic [7:0] SegBlank = 8'hFF;
    localparam logic [7:0] SegF     = 8'h71;
    localparam logic [7:0] SegT     = 8'hE1;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] seg;
        case (d)
            4'd0:    seg = 8'h03;
            4'd1:    seg = 8'h9F;
            4'd2:    seg = 8'h25;
            4'd3:    seg = 8'h0D;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h49;
            4'd6:    seg = 8'h41;
            4'd7:    seg = 8'h1F;
            4'd8:    seg = 8'h01;
            4'd9:    seg = 8'h09;
            default: seg = SegBlank;
        endcase
        return seg;
    endfunction

    // One double-dabble correction: add 3 to every nibble that is 5 or more.
    function automatic logic [BcdW-1:0] dd_adjust(input logic [BcdW-1:0] v);
        logic [BcdW-1:0] r;
        r = v;
        for (int i = 0; i < BcdW / 4; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble engine: 16-bit binary to 5 BCD digits, one bit
// per cycle. done pulses during the cycle of the final shift.
module bin2bcd_seq
    import disp_consumer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BinW-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic [BcdW-1:0] bcd
);

    logic [BinW-1:0] r_bin;
    logic [BcdW-1:0] r_bcd;
    logic [3:0]      r_cnt;
    logic            r_busy;
    logic [BcdW-1:0] w_adj;

    assign w_adj = dd_adjust(r_bcd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_bin  <= bin;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
            r_cnt          <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == 4'd15);
    assign bcd  = r_bcd;

endmodule

// File: rtl/disp_consumer.sv
// clk_2 read-side endpoint: accepts words from the CDC buffer, converts them
// to decimal and scans them with a source tag and prog onto an 8-digit display.
module disp_consumer
    import disp_consumer_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_2_valid,
    input  logic [15:0] data_2,
    input  logic [1:0]  modules,
    input  logic [2:0]  prog,
    output logic        ready,
    output logic        overrun,
    output logic [7:0]  an,
    output logic [7:0]  dec_ddp
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_e          r_state;
    logic            r_ready;
    logic            r_overrun;
    logic [BcdW-1:0] r_disp;
    logic [CntW-1:0] r_scan_cnt;
    logic [2:0]      r_digit_idx;
    logic [7:0]      r_an;
    logic [7:0]      r_dec;

    logic            w_start;
    logic            w_busy;
    logic            w_done;
    logic [BcdW-1:0] w_bcd;
    logic            w_blank;
    logic [7:0]      w_seg;
    logic            w_load;

    assign w_start = (r_state == StIdle) && data_2_valid;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (data_2),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_ready   <= 1'b1;
            r_overrun <= 1'b0;
            r_disp    <= '0;
        end else begin
            if (data_2_valid && !r_ready) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (data_2_valid) begin
                        r_state <= StConv;
                        r_ready <= 1'b0;
                    end
                end
                StConv: begin
                    if (w_done) begin
                        r_state <= StCommit;
                    end else if (!w_busy) begin
                        // Engine idle without finishing: recover rather than stall.
                        r_state <= StIdle;
                        r_ready <= 1'b1;
                    end
                end
                StCommit: begin
                    r_disp  <= w_bcd;
                    r_ready <= 1'b1;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Digit content for the current index; leading zeros above digit 0 blank.
    always_comb begin
        w_blank = 1'b0;
        w_seg   = SegBlank;
        unique case (r_digit_idx)
            3'd0: w_seg = seg_digit(r_disp[3:0]);
            3'd1: begin
                w_blank = (r_disp[19:4] == '0);
                w_seg   = seg_digit(r_disp[7:4]);
            end
            3'd2: begin
                w_blank = (r_disp[19:8] == '0);
                w_seg   = seg_digit(r_disp[11:8]);
            end
            3'd3: begin
                w_blank = (r_disp[19:12] == '0);
                w_seg   = seg_digit(r_disp[15:12]);
            end
            3'd4: begin
                w_blank = (r_disp[19:16] == '0);
                w_seg   = seg_digit(r_disp[19:16]);
            end
            3'd5: w_blank = 1'b1;
            3'd6: begin
                case (tag_e'(modules))
                    TagFib:   w_seg = SegF;
                    TagTimer: w_seg = SegT;
                    default:  w_blank = 1'b1;
                endcase
            end
            3'd7: w_seg = seg_digit({1'b0, prog});
            default: w_blank = 1'b1;
        endcase
    end

    // Outputs are loaded only at the start of each digit slot, so value and
    // live-input changes take effect at the next scan of that digit.
    assign w_load = (r_scan_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
            r_an        <= 8'hFF;
            r_dec       <= SegBlank;
        end else begin
            if (r_scan_cnt == CntW'(SCAN_DIV - 1)) begin
                r_scan_cnt  <= '0;
                r_digit_idx <= r_digit_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + CntW'(1);
            end
            if (w_load) begin
                r_an  <= w_blank ? 8'hFF : ~(8'd1 << r_digit_idx);
                r_dec <= w_blank ? SegBlank : w_seg;
            end
        end
    end

    assign ready   = r_ready;
    assign overrun = r_overrun;
    assign an      = r_an;
    assign dec_ddp = r_dec;

endmodule
